mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 20, is the accumulator and result width in bits; legal range is 17..32.
REQ-002 Parameter LEN_W, default 8, is the width of the beat-count field.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: a one-cycle request to begin a dot-product of len beats.
REQ-006 Port len, input, LEN_W bits: the number of products to accumulate, sampled with start.
REQ-007 Port in_valid, input, 1 bit: prod is valid this cycle.
REQ-008 Port prod, input, 16 bits: the unsigned product from the upstream 8x8 Wallace multiplier.
REQ-009 Port in_ready, output, 1 bit: the block accepts prod this cycle.
REQ-010 Port out_valid, output, 1 bit: sum and sat are valid.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 Port sum, output, ACC_W bits: the accumulated result.
REQ-013 Port sat, output, 1 bit: the sum saturated during this job.
REQ-014 Port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-015 The FSM shall have exactly three states: IDLE, ACC and DONE.
REQ-016 In IDLE, start=1 with len!=0 shall load cnt=len, clear acc and sat, and enter ACC on the next cycle.
REQ-017 In IDLE, start=1 with len=0 shall clear acc and sat and enter DONE directly (result sum=0).
REQ-018 start shall be ignored in ACC and DONE; it shall not restart or corrupt the job in progress.
REQ-019 in_ready shall be 1 only in ACC; an input beat is accepted only when in_valid && in_ready.
REQ-020 On each accepted beat: acc <= acc + zero-extended prod, and cnt <= cnt-1.
REQ-021 Saturation: if the true sum exceeds 2^ACC_W-1, acc shall become all-ones and sat shall be set; once set, sat shall stay set for the rest of the job.
REQ-022 While saturated, further beats shall still be consumed and counted, and acc shall remain all-ones.
REQ-023 An accepted beat with cnt==1 shall move the FSM to DONE; out_valid shall rise the cycle after that beat, with that beat included in sum.
REQ-024 in_valid=0 in ACC shall stall the job with no state change and no timeout.
REQ-025 In DONE: out_valid=1; sum and sat shall be stable until the handshake.
REQ-026 In DONE, out_ready=1 shall return the FSM to IDLE next cycle; out_valid shall fall that cycle, and sum and sat shall hold their values until the next start.
REQ-027 Backpressure: out_ready=0 shall hold DONE indefinitely; in_ready shall stay 0 throughout.
REQ-028 A start arriving in the same cycle as the DONE handshake shall be ignored; start is honoured only while in IDLE.
REQ-029 sum shall equal acc (registered output, no combinational path from prod); out_valid and in_ready shall be decoded from state only.
REQ-030 busy shall be 1 in ACC and DONE, and 0 in IDLE.
REQ-031 Throughput shall be one beat per cycle in ACC; total job latency is len accepted beats + 1 cycle to out_valid.

Reset
REQ-032 rst_n=0 shall, asynchronously, force state=IDLE, acc=0, cnt=0 and sat=0.
REQ-033 Consequently, during reset: sum=0, out_valid=0, in_ready=0, busy=0.
REQ-034 Reset asserted mid-job shall abandon the job with no partial result emitted.
REQ-035 After rst_n deasserts, the block shall sit idle until start.

Verification
REQ-036 Dot product: start, len=4; prods 6, 12, 20, 30 on consecutive cycles -> out_valid 1 cycle after 4th beat, sum=68, sat=0.
REQ-037 Stall and backpressure: len=3, in_valid gaps of 2 cycles, prods 65025 x3, out_ready=0 for 5 cycles -> sum=195075 held stable, in_ready=0 in DONE, IDLE after out_ready.
REQ-038 Saturation: len=20, all prods 65025 -> sat rises on the 17th beat, final sum=1048575 (ACC_W=20), sat=1, all 20 beats consumed.
REQ-039 Zero length: start with len=0 -> out_valid next cycle, sum=0, sat=0, no beats accepted.
REQ-040 Reset mid-job: len=5, rst_n=0 after 2 beats -> immediate IDLE, sum=0, no out_valid; a new job len=1, prod=255 -> sum=255.
REQ-041 Ignored start: start pulsed during ACC with len=9 -> original len=2 job completes with 2 beats; start pulsed in DONE is ignored.

Source files
------------

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums len unsigned 16-bit products into a saturating
// ACC_W-bit accumulator and presents the result on a valid/ready handshake.
module mac_accumulator #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      prod,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   sum_ext;

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    // Once saturated the accumulator pins at all-ones for the rest of the job.
                    if (sat_q || sum_ext[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = acc_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator with ACC_W=20, LEN_W=8.
module tb_mac_accumulator;

    localparam int unsigned ACC_W = 20;
    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [15:0]      prod;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             busy;

    int unsigned errors;
    int unsigned checks;

    mac_accumulator #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .prod     (prod),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .sat      (sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p);
        in_valid = 1'b1;
        prod     = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_job(input logic [LEN_W-1:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b0;

        #2;
        check("rst_sum", 32'(sum), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_reset_busy", 32'(busy), 0);

        // Basic dot product: 6+12+20+30 = 68
        begin_job(8'd4);
        check("dp_in_ready", 32'(in_ready), 1);
        check("dp_busy", 32'(busy), 1);
        beat(16'd6);
        beat(16'd12);
        beat(16'd20);
        check("dp_not_done_3", 32'(out_valid), 0);
        beat(16'd30);
        check("dp_out_valid", 32'(out_valid), 1);
        check("dp_sum", 32'(sum), 68);
        check("dp_sat", 32'(sat), 0);
        check("dp_in_ready_done", 32'(in_ready), 0);
        handshake();
        check("dp_idle_out_valid", 32'(out_valid), 0);
        check("dp_idle_busy", 32'(busy), 0);
        check("dp_sum_held", 32'(sum), 68);

        // Stalls and backpressure: 3 * 65025 = 195075
        begin_job(8'd3);
        for (int i = 0; i < 3; i++) begin
            beat(16'd65025);
            if (i < 2) begin
                prod = 16'd999;
                tick();
                tick();
                check("stall_in_ready", 32'(in_ready), 1);
                check("stall_sum", 32'(sum), 32'(65025 * (i + 1)));
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_sum", 32'(sum), 195075);
            tick();
        end
        handshake();
        check("bp_idle_busy", 32'(busy), 0);
        check("bp_sum_held", 32'(sum), 195075);

        // Saturation: 16 * 65025 = 1040400 fits, the 17th beat overflows 2^20-1
        begin_job(8'd20);
        for (int i = 1; i <= 20; i++) begin
            beat(16'd65025);
            if (i == 16) begin
                check("sat_16_sum", 32'(sum), 1040400);
                check("sat_16_flag", 32'(sat), 0);
            end
            if (i == 17) begin
                check("sat_17_sum", 32'(sum), 1048575);
                check("sat_17_flag", 32'(sat), 1);
            end
            if (i == 19) begin
                check("sat_19_in_ready", 32'(in_ready), 1);
                check("sat_19_out_valid", 32'(out_valid), 0);
                check("sat_19_sum", 32'(sum), 1048575);
            end
        end
        check("sat_out_valid", 32'(out_valid), 1);
        check("sat_sum", 32'(sum), 1048575);
        check("sat_flag", 32'(sat), 1);
        handshake();

        // Zero length: straight to DONE with cleared sum and sat
        in_valid = 1'b1;
        prod     = 16'd77;
        begin_job(8'd0);
        check("zl_out_valid", 32'(out_valid), 1);
        check("zl_in_ready", 32'(in_ready), 0);
        check("zl_sum", 32'(sum), 0);
        check("zl_sat", 32'(sat), 0);
        tick();
        check("zl_sum_hold", 32'(sum), 0);
        in_valid = 1'b0;
        handshake();
        check("zl_idle", 32'(busy), 0);

        // Reset mid-job abandons the job
        begin_job(8'd5);
        beat(16'd100);
        beat(16'd100);
        check("rm_partial_sum", 32'(sum), 200);
        rst_n = 1'b0;
        #1;
        check("rm_sum", 32'(sum), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_out_valid", 32'(out_valid), 0);
        check("rm_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("rm_idle_busy", 32'(busy), 0);
        check("rm_idle_out_valid", 32'(out_valid), 0);
        begin_job(8'd1);
        beat(16'd255);
        check("rm_new_out_valid", 32'(out_valid), 1);
        check("rm_new_sum", 32'(sum), 255);
        handshake();

        // Start ignored in ACC and DONE
        begin_job(8'd2);
        start    = 1'b1;
        len      = 8'd9;
        in_valid = 1'b1;
        prod     = 16'd40;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("ig_acc_sum", 32'(sum), 40);
        check("ig_acc_in_ready", 32'(in_ready), 1);
        beat(16'd2);
        check("ig_done_out_valid", 32'(out_valid), 1);
        check("ig_done_sum", 32'(sum), 42);
        start = 1'b1;
        len   = 8'd9;
        tick();
        check("ig_done_hold", 32'(out_valid), 1);
        check("ig_done_hold_sum", 32'(sum), 42);
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("ig_hs_busy", 32'(busy), 0);
        check("ig_hs_in_ready", 32'(in_ready), 0);
        tick();
        check("ig_hs_still_idle", 32'(busy), 0);
        check("ig_hs_sum_held", 32'(sum), 42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
